// File: rtl/uart_frame_loader_pkg.sv
// uart_frame_loader_pkg: one-hot state encoding, default timing and byte/sample width relation shared by the frame loader
package uart_frame_loader_pkg;
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LO    = 5'b00010,
    S_HI    = 5'b00100,
    S_START = 5'b01000,
    S_WAIT  = 5'b10000
  } state_t;
  localparam int BYTE_W_DEF = 8;
  localparam int T_GAP_DEF = 52070;
  function automatic int sample_w(input int byte_w);
    return 2 * byte_w;
  endfunction
endpackage

// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if: rx byte in (rx_data_i/rx_done_i), buffer write out (wr_en_o/wr_addr_o/wr_data_o), fft handshake (fft_start_o/fft_done_i), status (busy_o/gap_err_o/drop_o)
interface uart_frame_loader_if import uart_frame_loader_pkg::*; #(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int SIZE = 5
);
  logic [BYTE_W-1:0] rx_data_i;
  logic rx_done_i;
  logic wr_en_o;
  logic [SIZE-1:0] wr_addr_o;
  logic [sample_w(BYTE_W)-1:0] wr_data_o;
  logic fft_start_o;
  logic fft_done_i;
  logic busy_o;
  logic gap_err_o;
  logic drop_o;
  modport master (
    output rx_data_i, rx_done_i, fft_done_i,
    input  wr_en_o, wr_addr_o, wr_data_o, fft_start_o, busy_o, gap_err_o, drop_o
  );
  modport slave (
    input  rx_data_i, rx_done_i, fft_done_i,
    output wr_en_o, wr_addr_o, wr_data_o, fft_start_o, busy_o, gap_err_o, drop_o
  );
endinterface

// File: rtl/uart_frame_loader_gap_timer.sv
// uart_frame_loader_gap_timer: saturating inter-byte gap counter (clk, rst, enable, clear in; expire out while count==T_GAP)
module uart_frame_loader_gap_timer import uart_frame_loader_pkg::*; #(
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(T_GAP + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!enable || clear) ? '0 : (cnt == W'(T_GAP)) ? cnt : cnt + 1'b1;
  assign expire = enable && cnt == W'(T_GAP);
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: pairs rx bytes into samples written to buffer 0..N-1, starts the fft and waits for done (clk, rst, bus slave modport)
module uart_frame_loader import uart_frame_loader_pkg::*; #(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int N = 32,
  parameter int SIZE = 5,
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic clk,
  input  logic rst,
  uart_frame_loader_if.slave bus
);
  state_t st;
  logic [SIZE-1:0] idx;
  logic [BYTE_W-1:0] lo_byte;
  logic gap_en;
  logic expire;
  assign gap_en = st == S_HI || (st == S_LO && idx != '0);
  uart_frame_loader_gap_timer #(.T_GAP(T_GAP)) u_gap_timer (
    .clk(clk),
    .rst(rst),
    .enable(gap_en),
    .clear(bus.rx_done_i),
    .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_LO;
      idx <= '0;
      lo_byte <= '0;
      bus.wr_en_o <= 1'b0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
      bus.fft_start_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.gap_err_o <= 1'b0;
      bus.drop_o <= 1'b0;
    end else begin
      bus.wr_en_o <= 1'b0;
      bus.fft_start_o <= 1'b0;
      bus.gap_err_o <= 1'b0;
      bus.drop_o <= 1'b0;
      case (st)
        S_LO:
          if (bus.rx_done_i) begin
            lo_byte <= bus.rx_data_i;
            bus.busy_o <= 1'b1;
            st <= S_HI;
          end else if (expire) begin
            bus.gap_err_o <= 1'b1;
            bus.busy_o <= 1'b0;
            idx <= '0;
          end
        S_HI:
          if (bus.rx_done_i) begin
            bus.wr_en_o <= 1'b1;
            bus.wr_addr_o <= idx;
            bus.wr_data_o <= {bus.rx_data_i, lo_byte};
            idx <= (idx == SIZE'(N - 1)) ? '0 : idx + 1'b1;
            st <= (idx == SIZE'(N - 1)) ? S_START : S_LO;
          end else if (expire) begin
            bus.gap_err_o <= 1'b1;
            bus.busy_o <= 1'b0;
            idx <= '0;
            st <= S_LO;
          end
        S_START: begin
          bus.fft_start_o <= 1'b1;
          bus.drop_o <= bus.rx_done_i;
          st <= S_WAIT;
        end
        S_WAIT: begin
          bus.drop_o <= bus.rx_done_i;
          if (bus.fft_done_i) begin
            bus.busy_o <= 1'b0;
            st <= S_LO;
          end
        end
        default: begin
          idx <= '0;
          bus.busy_o <= 1'b0;
          st <= S_LO;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed plus random byte streams checked by a frame-level model feeding an event scoreboard
module tb_uart_frame_loader;
  localparam int T_GAP = 20;
  localparam int N = 32;
  localparam int EV_WR = 0, EV_START = 1, EV_GAP = 2, EV_DROP = 3;
  typedef struct {int kind; int addr; int data; int cyc;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_frame_loader_if #(.BYTE_W(8), .SIZE(5)) bus ();
  uart_frame_loader #(.BYTE_W(8), .N(N), .SIZE(5), .T_GAP(T_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, events = 0, cyc = 0, last_wr_cyc = -10;
  ev_t q[$];
  int pos = 0, gap = 0, wait_age = 0;
  bit waiting = 0;
  logic [7:0] lo_m = '0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic string kname(input int k);
    return k == EV_WR ? "write" : k == EV_START ? "start" : k == EV_GAP ? "gap_err" : "drop";
  endfunction
  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic expect_ev(input int kind);
    ev_t e;
    checks++;
    events++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output at cycle %0d", kname(kind), cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind) begin
      errors++;
      $display("FAIL event_kind: got %s expected %s at cycle %0d", kname(kind), kname(e.kind), cyc);
    end else if (kind == EV_WR && (int'(bus.wr_addr_o) != e.addr || int'(bus.wr_data_o) != e.data || cyc != e.cyc)) begin
      errors++;
      $display("FAIL write: got addr %0d data %04h cyc %0d expected addr %0d data %04h cyc %0d",
               bus.wr_addr_o, bus.wr_data_o, cyc, e.addr, e.data, e.cyc);
    end else if (kind == EV_START && cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL start_timing: got cycle %0d expected %0d", cyc, last_wr_cyc + 1);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.wr_en_o) begin
      expect_ev(EV_WR);
      last_wr_cyc = cyc;
    end
    if (bus.fft_start_o) expect_ev(EV_START);
    if (bus.gap_err_o) expect_ev(EV_GAP);
    if (bus.drop_o) expect_ev(EV_DROP);
  end
  // One clock of stimulus; the model tracks frame position, gap length and fft wait at byte level.
  task automatic cycle(input bit rx, input logic [7:0] d, input bit fd);
    bit was_waiting, f;
    was_waiting = waiting;
    if (waiting) wait_age++;
    f = fd && !(waiting && wait_age < 2);
    bus.rx_done_i = rx;
    bus.rx_data_i = d;
    bus.fft_done_i = f;
    if (rx) begin
      gap = 0;
      if (was_waiting) q.push_back('{EV_DROP, 0, 0, 0});
      else if (pos % 2 == 0) begin
        lo_m = d;
        pos++;
      end else begin
        q.push_back('{EV_WR, pos / 2, int'({d, lo_m}), cyc + 1});
        pos++;
        if (pos == 2 * N) begin
          q.push_back('{EV_START, 0, 0, 0});
          waiting = 1;
          wait_age = 0;
          pos = 0;
        end
      end
    end else begin
      gap++;
      if (!waiting && pos > 0 && gap == T_GAP + 1) begin
        q.push_back('{EV_GAP, 0, 0, 0});
        pos = 0;
      end
    end
    if (f && was_waiting) waiting = 0;
    @(posedge clk);
    #1;
    bus.rx_done_i = 1'b0;
    bus.fft_done_i = 1'b0;
    check_eq("busy", int'(bus.busy_o), int'(pos > 0 || waiting));
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0);
  endtask
  task automatic check_zero(input string tag);
    check_eq({tag, "_wr_en"}, int'(bus.wr_en_o), 0);
    check_eq({tag, "_wr_addr"}, int'(bus.wr_addr_o), 0);
    check_eq({tag, "_wr_data"}, int'(bus.wr_data_o), 0);
    check_eq({tag, "_start"}, int'(bus.fft_start_o), 0);
    check_eq({tag, "_busy"}, int'(bus.busy_o), 0);
    check_eq({tag, "_gap_err"}, int'(bus.gap_err_o), 0);
    check_eq({tag, "_drop"}, int'(bus.drop_o), 0);
  endtask
  initial begin
    int ev0;
    bus.rx_done_i = 1'b0;
    bus.rx_data_i = '0;
    bus.fft_done_i = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2 * N; i++) cycle(1'b1, 8'(i), 1'b0);
    idle(4);
    cycle(1'b1, 8'hAA, 1'b0);
    idle(3);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    idle(T_GAP + 3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    idle(T_GAP + 2);
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    idle(T_GAP + 3);
    ev0 = events;
    idle(10 * T_GAP);
    check_eq("idle_events", events - ev0, 0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    idle(2);
    #3 rst = 1'b1;
    #1 check_zero("midreset");
    pos = 0;
    gap = 0;
    waiting = 0;
    check_eq("midreset_queue", q.size(), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    idle(T_GAP);
    cycle(1'b1, 8'h56, 1'b0);
    idle(T_GAP);
    cycle(1'b1, 8'h9A, 1'b0);
    cycle(1'b1, 8'hBC, 1'b0);
    idle(T_GAP + 3);
    repeat (1500) begin
      if ($urandom_range(0, 49) == 0) idle($urandom_range(T_GAP - 1, T_GAP + 2));
      cycle($urandom_range(0, 3) != 0, 8'($urandom), waiting ? $urandom_range(0, 3) == 0 : $urandom_range(0, 15) == 0);
    end
    while (waiting) cycle(1'b0, 8'h00, 1'b1);
    idle(T_GAP + 3);
    check_eq("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
